pool_channel_scheduler: RTL

Shares one pooling engine (pooling controller plus datapath) among N_CH channel requesters, each owning one feature map of size SYS_WIDTH x SYS_WIDTH.
- Grants the engine round-robin, one map per grant.
- Pulses the engine start.
- Counts pool_done pulses until the map's (SYS_WIDTH/2)^2 outputs are produced.
- Signals per-channel completion.

Sits between the systolic-array output channel muxing and the pooling controller.

---
 rtl/pool_pkg.sv | 24 ++
 rtl/rr_arbiter_comb.sv | 42 ++++
 rtl/pool_channel_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the pooling-engine channel scheduler.
//   SYS_WIDTH_DEF      : default feature-map row width (must be even)
//   pool_sched_state_t : scheduler FSM state encoding
//   total_out()        : pooled outputs produced for one width x width map
// ---------------------------------------------------------------------------
package pool_pkg;

  localparam int SYS_WIDTH_DEF = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } pool_sched_state_t;

  // 2x2 pooling with stride 2 halves each dimension.
  function automatic int total_out(input int width);
    return (width / 2) * (width / 2);
  endfunction

endpackage

// File: rtl/rr_arbiter_comb.sv
// ---------------------------------------------------------------------------
// rr_arbiter_comb
// Purely combinational round-robin pick. The search starts one position after
// last_idx and wraps, so the previous winner has the lowest priority.
// Ports:
//   req        in  N_CH   request vector
//   last_idx   in  IDX_W  index of the most recently served requester
//   gnt_onehot out N_CH   one-hot winner (zero when no request)
//   gnt_idx    out IDX_W  binary winner index (zero when no request)
//   any        out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter_comb #(
  parameter  int N_CH  = 4,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [N_CH-1:0]  gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    // k runs 1..N_CH so the last candidate examined is last_idx itself;
    // a lone requester that was just served is therefore re-granted.
    for (int k = 1; k <= N_CH; k++) begin
      cand = IDX_W'((int'(last_idx) + k) % N_CH);
      if (!any && req[cand]) begin
        any              = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pool_channel_scheduler.sv
// ---------------------------------------------------------------------------
// pool_channel_scheduler
// Time-shares one pooling engine among N_CH channel requesters, one feature
// map per grant, granted round-robin.
// Ports:
//   clk, nrst     clock (rising edge), asynchronous active-low reset
//   ch_req        per-channel job request (level, held until ch_done)
//   abort         synchronous abort of the current job
//   pool_done     one pulse per pooled output from the pooling controller
//   pool_start    one-cycle start pulse to the pooling controller
//   grant         one-hot engine owner, zero when free
//   grant_idx     binary owner index, valid while busy
//   busy          engine owned (START or RUN)
//   ch_done       one-cycle one-hot completion pulse
//   out_count     pooled outputs received in the current job
//   err_spurious  sticky: pool_done seen outside RUN
//   dbg_state     current FSM state
//
// Handshake: a channel raises ch_req and holds it. The scheduler arbitrates
// only in IDLE; the winner sees grant/pool_start the next cycle. The job ends
// when TOTAL_OUT pool_done pulses have arrived, marked by ch_done for one
// cycle, after which the channel may drop or keep its request. Changes of
// ch_req during a job are not observed until the scheduler is back in IDLE.
// abort ends the job early with no ch_done and leaves the priority untouched.
// ---------------------------------------------------------------------------
module pool_channel_scheduler
  import pool_pkg::*;
#(
  parameter  int N_CH      = 4,
  parameter  int SYS_WIDTH = SYS_WIDTH_DEF,
  localparam int TOTAL_OUT = total_out(SYS_WIDTH),
  localparam int CNT_W     = $clog2(TOTAL_OUT + 1),
  localparam int IDX_W     = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [N_CH-1:0]  ch_req,
  input  logic             abort,
  input  logic             pool_done,
  output logic             pool_start,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic [N_CH-1:0]  ch_done,
  output logic [CNT_W-1:0] out_count,
  output logic             err_spurious,
  output logic [1:0]       dbg_state
);

  pool_sched_state_t state_q, state_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [N_CH-1:0]   arb_onehot;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;

  rr_arbiter_comb #(.N_CH(N_CH)) u_arb (
    .req        (ch_req),
    .last_idx   (last_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .any        (arb_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (pool_done && (state_q != RUN));

    case (state_q)
      IDLE: begin
        // abort in IDLE suppresses arbitration for that cycle
        if (!abort && arb_any) begin
          grant_d = arb_onehot;
          idx_d   = arb_idx;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        // Saturating guard: the count can never pass TOTAL_OUT.
        if (pool_done && (cnt_q < CNT_W'(TOTAL_OUT))) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TOTAL_OUT - 1)) state_d = DONE;
        end
      end
      DONE: begin
        last_d  = idx_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // abort overrides everything outside IDLE, including a final pool_done.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      grant_d = '0;
      cnt_d   = '0;
      last_d  = last_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_CH - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pool_start   = (state_q == START);
  assign busy         = (state_q == START) || (state_q == RUN);
  // grant_q still holds the owner during DONE, so it doubles as the one-hot
  // completion vector; an abort in that cycle cancels the pulse.
  assign ch_done      = ((state_q == DONE) && !abort) ? grant_q : '0;
  assign grant        = grant_q;
  assign grant_idx    = idx_q;
  assign out_count    = cnt_q;
  assign err_spurious = err_q;
  assign dbg_state    = state_q;

endmodule
